// File: rtl/range_sched_pkg.sv
// range_sched_pkg: shared types and helpers for the range scheduler.
//   state_t  - scheduler FSM states (IDLE, ISSUE, WAIT, RESP)
//   clog2    - ceiling log2 for elaboration-time width math
//   timer_w  - width of the WAIT timer for a given TIMEOUT
package range_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // The timer has to hold every value 0..TIMEOUT.
  function automatic int timer_w(input int timeout);
    return (clog2(timeout + 1) < 1) ? 1 : clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/range_sched_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req    - per-requester valid bits
//   ptr    - index that has highest priority this cycle
//   onehot - one-hot grant (zero when nothing requests)
//   idx    - index of the granted requester
//   any    - at least one requester is valid
module rr_pick
  import range_sched_pkg::*;
#(
  parameter  int N   = 3,
  localparam int IDW = (N > 1) ? clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   onehot,
  output logic [IDW-1:0] idx,
  output logic           any
);

  // Scan ptr, ptr+1, ... wrapping modulo N; the first set bit wins.
  always_comb begin
    int j;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/range_sched.sv
// range_sched: shares one W-bit range unit among N requesters, round-robin.
// One transaction in flight: accept -> issue to unit -> wait for done or
// timeout -> one-cycle tagged response.
//   clk, rst                 - clock, synchronous active-high reset
//   req_valid/req_data       - per-requester requests (slice i = requester i)
//   req_ready                - one-hot accept strobe (combinational)
//   unit_valid/unit_ready    - issue handshake to the shared unit
//   unit_in                  - payload to the unit
//   unit_done/unit_out       - unit result
//   rsp_valid/rsp_id/
//   rsp_data/rsp_err         - response pulse (err = timeout, data 0)
//   busy                     - high outside IDLE
module range_sched
  import range_sched_pkg::*;
#(
  parameter  int W       = 4,
  parameter  int N       = 3,
  parameter  int TIMEOUT = 15,
  localparam int IDW     = (N > 1) ? clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   req_ready,
  output logic           unit_valid,
  input  logic           unit_ready,
  output logic [W-1:0]   unit_in,
  input  logic           unit_done,
  input  logic [W-1:0]   unit_out,
  output logic           rsp_valid,
  output logic [IDW-1:0] rsp_id,
  output logic [W-1:0]   rsp_data,
  output logic           rsp_err,
  output logic           busy
);

  localparam int            TW   = timer_w(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  state_t         state, state_d;
  logic [IDW-1:0] ptr;
  logic [TW-1:0]  timer;
  logic [IDW-1:0] id_q;
  logic [W-1:0]   data_q;
  logic [W-1:0]   res_q;
  logic           err_q;

  logic [N-1:0]   pick_onehot;
  logic [IDW-1:0] pick_idx;
  logic           pick_any;
  logic           accept;

  rr_pick #(.N(N)) u_pick (
    .req    (req_valid),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Next state and outputs
  always_comb begin
    state_d    = state;
    accept     = 1'b0;
    req_ready  = '0;
    unit_valid = 1'b0;
    unit_in    = '0;
    rsp_valid  = 1'b0;
    rsp_id     = '0;
    rsp_data   = '0;
    rsp_err    = 1'b0;
    case (state)
      IDLE: begin
        // Never hand out an accept strobe that reset is about to discard.
        if (!rst && pick_any) begin
          req_ready = pick_onehot;
          accept    = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        unit_valid = 1'b1;
        unit_in    = data_q;
        if (unit_ready) state_d = WAIT;
      end
      WAIT: begin
        if (unit_done || timer == TMAX) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = id_q;
        rsp_data  = res_q;
        rsp_err   = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // State and transaction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      timer  <= '0;
      id_q   <= '0;
      data_q <= '0;
      res_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        id_q   <= pick_idx;
        data_q <= req_data[int'(pick_idx)*W +: W];
      end
      if (state == ISSUE && unit_ready) timer <= '0;
      if (state == WAIT) begin
        timer <= timer + 1'b1;
        // A result arriving on the last permitted cycle still counts.
        if (unit_done) begin
          res_q <= unit_out;
          err_q <= 1'b0;
        end else if (timer == TMAX) begin
          res_q <= '0;
          err_q <= 1'b1;
        end
      end
      if (state == RESP) ptr <= (id_q == IDW'(N - 1)) ? '0 : id_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_range_sched.sv
// tb_range_sched: directed self-checking bench for range_sched (W=4, N=3,
// TIMEOUT=15). Inputs change on the falling edge; outputs are checked 1 ns
// later, well away from the rising edge.
module tb_range_sched;

  localparam int W       = 4;
  localparam int N       = 3;
  localparam int TIMEOUT = 15;
  localparam int IDW     = 2;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           unit_valid;
  logic           unit_ready;
  logic [W-1:0]   unit_in;
  logic           unit_done;
  logic [W-1:0]   unit_out;
  logic           rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;
  logic           busy;

  int n_chk  = 0;
  int n_fail = 0;

  range_sched #(.W(W), .N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .unit_valid (unit_valid),
    .unit_ready (unit_ready),
    .unit_in    (unit_in),
    .unit_done  (unit_done),
    .unit_out   (unit_out),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One transaction with an immediately ready unit and done one cycle later.
  task automatic run_txn(input logic [2:0] rv, input logic [11:0] rd,
                         input logic [3:0] out, input int g, input logic [3:0] din);
    tick(); req_valid = rv; req_data = rd; unit_ready = 1'b1; unit_done = 1'b0;
    #1;
    chk("acc_ready", 32'(req_ready), 32'(1) << g);
    chk("acc_busy",  32'(busy), 32'd0);
    tick();
    #1;
    chk("iss_valid", 32'(unit_valid), 32'd1);
    chk("iss_in",    32'(unit_in), 32'(din));
    chk("iss_ready", 32'(req_ready), 32'd0);
    chk("iss_busy",  32'(busy), 32'd1);
    tick(); unit_done = 1'b1; unit_out = out;
    #1;
    chk("wait_uvld", 32'(unit_valid), 32'd0);
    chk("wait_rsp",  32'(rsp_valid), 32'd0);
    chk("wait_busy", 32'(busy), 32'd1);
    tick(); unit_done = 1'b0;
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_id",    32'(rsp_id), 32'(g));
    chk("rsp_data",  32'(rsp_data), 32'(out));
    chk("rsp_err",   32'(rsp_err), 32'd0);
    chk("rsp_busy",  32'(busy), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 3'b111; req_data = '0;
    unit_ready = 1'b0; unit_done = 1'b0; unit_out = '0;

    // Reset
    tick(); #1;
    chk("rst_ready0", 32'(req_ready), 32'd0);
    tick(); #1;
    chk("rst_ready1", 32'(req_ready), 32'd0);
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_uvld",   32'(unit_valid), 32'd0);
    chk("rst_uin",    32'(unit_in), 32'd0);
    chk("rst_rvld",   32'(rsp_valid), 32'd0);
    chk("rst_rid",    32'(rsp_id), 32'd0);
    chk("rst_rdata",  32'(rsp_data), 32'd0);
    chk("rst_rerr",   32'(rsp_err), 32'd0);
    tick(); rst = 1'b0; req_valid = '0;
    #1;
    chk("idle_busy", 32'(busy), 32'd0);

    // Single request from requester 1
    run_txn(3'b010, 12'h0A0, 4'h5, 1, 4'hA);
    tick(); req_valid = '0;
    #1;
    chk("post_rvld", 32'(rsp_valid), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);

    // Back to ptr = 0, then fairness with everybody requesting
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    run_txn(3'b111, 12'hCBA, 4'h1, 0, 4'hA);
    run_txn(3'b111, 12'hCBA, 4'h2, 1, 4'hB);
    run_txn(3'b111, 12'hCBA, 4'h3, 2, 4'hC);
    run_txn(3'b111, 12'hCBA, 4'h4, 0, 4'hA);

    // Stall in ISSUE (ptr = 1, only requester 0 asks)
    tick(); req_valid = 3'b001; req_data = 12'h007; unit_ready = 1'b0;
    #1;
    chk("stall_acc", 32'(req_ready), 32'b001);
    for (int i = 0; i < 5; i++) begin
      tick(); req_valid = '0;
      #1;
      chk("stall_uvld", 32'(unit_valid), 32'd1);
      chk("stall_uin",  32'(unit_in), 32'h7);
    end
    tick(); unit_ready = 1'b1;
    #1;
    chk("stall_hs", 32'(unit_valid), 32'd1);
    tick(); unit_ready = 1'b0;
    #1;
    chk("stall_wait_uvld", 32'(unit_valid), 32'd0);
    chk("stall_wait_rsp",  32'(rsp_valid), 32'd0);
    tick(); unit_done = 1'b1; unit_out = 4'h3;
    #1;
    chk("stall_done_rsp", 32'(rsp_valid), 32'd0);
    tick(); unit_done = 1'b0;
    #1;
    chk("stall_rvld", 32'(rsp_valid), 32'd1);
    chk("stall_rid",  32'(rsp_id), 32'd0);
    chk("stall_rdat", 32'(rsp_data), 32'h3);
    chk("stall_rerr", 32'(rsp_err), 32'd0);

    // Timeout on requester 0 (ptr = 1)
    tick(); req_valid = 3'b001; req_data = 12'h009; unit_ready = 1'b1;
    #1;
    chk("to_acc", 32'(req_ready), 32'b001);
    tick(); req_valid = '0;
    #1;
    chk("to_hs", 32'(unit_valid), 32'd1);
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick(); unit_ready = 1'b0;
      #1;
      chk("to_wait_rsp", 32'(rsp_valid), 32'd0);
    end
    tick();
    #1;
    chk("to_rvld", 32'(rsp_valid), 32'd1);
    chk("to_rid",  32'(rsp_id), 32'd0);
    chk("to_rdat", 32'(rsp_data), 32'd0);
    chk("to_rerr", 32'(rsp_err), 32'd1);

    // Done on the last WAIT cycle; ptr advanced to 1 after the timeout
    tick(); req_valid = 3'b111; req_data = 12'hCBA; unit_ready = 1'b1;
    #1;
    chk("bd_acc", 32'(req_ready), 32'b010);
    tick(); req_valid = '0;
    #1;
    chk("bd_uin", 32'(unit_in), 32'hB);
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick(); unit_ready = 1'b0; unit_done = (k == TIMEOUT); unit_out = 4'h6;
      #1;
      chk("bd_wait_rsp", 32'(rsp_valid), 32'd0);
    end
    tick(); unit_done = 1'b0;
    #1;
    chk("bd_rvld", 32'(rsp_valid), 32'd1);
    chk("bd_rid",  32'(rsp_id), 32'd1);
    chk("bd_rdat", 32'(rsp_data), 32'h6);
    chk("bd_rerr", 32'(rsp_err), 32'd0);

    // Reset in WAIT (ptr = 2 beforehand)
    tick(); req_valid = 3'b111;
    #1;
    chk("rw_acc", 32'(req_ready), 32'b100);
    tick(); req_valid = '0; unit_ready = 1'b1;
    #1;
    chk("rw_uin", 32'(unit_in), 32'hC);
    tick(); unit_ready = 1'b0; rst = 1'b1;
    #1;
    chk("rw_rsp",  32'(rsp_valid), 32'd0);
    chk("rw_busy", 32'(busy), 32'd1);
    tick(); rst = 1'b0; req_valid = 3'b111;
    #1;
    chk("rw_idle_busy", 32'(busy), 32'd0);
    chk("rw_idle_uvld", 32'(unit_valid), 32'd0);
    chk("rw_idle_rsp",  32'(rsp_valid), 32'd0);
    chk("rw_idle_err",  32'(rsp_err), 32'd0);
    chk("rw_grant0",    32'(req_ready), 32'b001);
    tick(); req_valid = '0;
    #1;
    chk("rw_no_rsp",  32'(rsp_valid), 32'd0);
    chk("rw_reissue", 32'(unit_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/range_sched.md
Name: range_sched

Overview:
- Round-robin scheduler that shares one W-bit range/slice unit among N requesters.
- Accepts one request at a time, issues it to the unit, and waits for the unit's done or a timeout.
- Returns a tagged response to the originating requester.
- Sits between requester-side range logic and the single shared range unit instance.

Parameters:
- W, 4, data width of request, unit and response payloads.
- N, 3, number of requesters (1..8).
- TIMEOUT, 15, maximum WAIT cycles before an error response (1..255).
- IDW, (N>1 ? clog2(N) : 1), requester id width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  N  per-requester request valid.
- req_data  input  N*W  packed payloads; requester i occupies bits [i*W+W-1 : i*W].
- req_ready  output  N  one-hot accept strobe, combinational.
- unit_valid  output  1  issue strobe to the shared unit.
- unit_ready  input  1  unit accepts the issue.
- unit_in  output  W  payload to the unit.
- unit_done  input  1  unit result valid.
- unit_out  input  W  unit result.
- rsp_valid  output  1  response pulse; no back-pressure.
- rsp_id  output  IDW  requester index the response belongs to.
- rsp_data  output  W  result, or 0 on error.
- rsp_err  output  1  1 = timeout.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous) takes effect at the next clk edge:
  - state = IDLE, ptr = 0, timer = 0, latched id/data = 0.
  - All outputs 0; req_ready = 0 while rst = 1.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, grant g = first set bit scanning ptr, ptr+1, ..., wrapping modulo N.
  - req_ready[g] = 1 combinationally that cycle; all other req_ready bits stay 0.
  - Latch g and req_data slice g, then go to ISSUE.
  - With no req_valid, stay in IDLE.
- ISSUE:
  - unit_valid = 1 and unit_in = latched data, held stable until unit_ready.
  - On unit_valid && unit_ready: timer = 0, go to WAIT.
  - unit_ready low stalls indefinitely; there is no timeout in ISSUE.
- WAIT:
  - unit_valid = 0; timer increments each cycle.
  - unit_done = 1: latch unit_out, err = 0, go to RESP. unit_done wins if it coincides with timer == TIMEOUT-1.
  - Otherwise timer == TIMEOUT-1: data = 0, err = 1, go to RESP.
  - unit_done outside WAIT is ignored; the unit guarantees latency of at least 1 cycle.
- RESP:
  - rsp_valid = 1 for exactly one cycle, with rsp_id, rsp_data and rsp_err registered.
  - ptr = (id + 1) mod N, then go to IDLE.
  - rsp_* outputs are 0 whenever rsp_valid = 0.
- Latency:
  - Best case, accept to rsp_valid = 3 cycles (IDLE -> ISSUE with immediate ready -> WAIT with done in first cycle -> RESP).
  - Timeout case, unit handshake to rsp_valid = TIMEOUT+1 cycles.
- Throughput: at most one transaction in flight; a new accept is possible in the cycle after RESP.
- Reset mid-operation abandons the transaction: no rsp_valid pulse, and ptr returns to 0.
- N = 1: grant is always requester 0, and rsp_id is a constant 0.
- A req_valid drop while not granted is legal. A granted request is consumed in its accept cycle.

Decomposition:
- Package range_sched_pkg:
  - State enum (IDLE = 0, ISSUE = 1, WAIT = 2, RESP = 3).
  - clog2 function.
  - Timer width constant TW = clog2(TIMEOUT+1).
- Sub-module rr_pick (parameter N): combinational.
  - Inputs req[N] and ptr[IDW].
  - Outputs onehot[N], idx[IDW], any.
  - Instantiated once.

Test Plan:
- Single request: N=3, req_valid=3'b010, req_data slice1=4'hA, unit_ready=1, unit_done next cycle with unit_out=4'h5 -> req_ready=3'b010 for 1 cycle, unit_in=4'hA, rsp_valid after 3 cycles with rsp_id=1, rsp_data=4'h5, rsp_err=0.
- Fairness: all three req_valid held high, unit immediate -> grants in order 0,1,2,0; exactly one req_ready bit per accept; busy low only in the IDLE cycles.
- Stall: unit_ready low for 5 cycles -> unit_valid high and unit_in constant throughout; WAIT is entered on the first ready; no timeout fires during the stall.
- Timeout: TIMEOUT=15, unit_done never asserted -> rsp_valid 16 cycles after the unit handshake, with rsp_err=1, rsp_data=0, correct rsp_id; ptr advances.
- Done on the boundary: unit_done asserted in the final WAIT cycle (timer=14) -> rsp_err=0, rsp_data=unit_out.
- Reset mid-WAIT: rst pulsed for one cycle in WAIT -> no rsp_valid; next cycle state=IDLE, all outputs 0; with all req_valid high, the next grant is requester 0.
